// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-FF synchroniser, 3-sample majority vote, and a valid/ready hold output.
// Latency: rx_valid rises 1 clk after the stop-bit centre sample, which is about 2 clk of sync plus 9.5 bit-times after the line falls.
// Backpressure: the byte is held until rx_valid&&rx_ready. A newer byte overwrites an unaccepted one and pulses rx_overrun.
//
// Ports:
//   clk          in   posedge clock
//   reset        in   synchronous, active-high
//   rx_serial    in   asynchronous serial line, idle high
//   rx_byte      out  received byte, stable while rx_valid=1
//   rx_valid     out  byte available, held until accepted
//   rx_ready     in   consumer accepts rx_byte when rx_valid&&rx_ready
//   rx_active    out  high from start detect until the stop-bit verdict
//   rx_frame_err out  1-cycle pulse when the stop bit is sampled 0
//   rx_overrun   out  1-cycle pulse when a byte completes while rx_valid is still held
`timescale 1ns/1ps
module uart_rx #(
  parameter int FREQUENCY = 10000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_active,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  // Same divisor formula as uart_tx, so both ends agree on the bit period.
  localparam int CLKS_PER_BIT = FREQUENCY / (16 * BAUD_RATE);
  localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;

  localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF_LAST = 8'(HALF_BIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t     state_q;
  logic [1:0] sync_q;        // sync_q[1] is the synchronised line (s_rx)
  logic [2:0] hist_q;        // last three s_rx values, used by the majority vote
  logic [7:0] clk_cnt_q;
  logic [2:0] bit_idx_q;
  logic [7:0] data_q;
  logic [7:0] rx_byte_q;
  logic       rx_valid_q;
  logic       rx_active_q;
  logic       rx_frame_err_q;
  logic       rx_overrun_q;

  logic s_rx;
  logic vote;

  assign s_rx = sync_q[1];
  // A single-cycle glitch can flip at most one of the three samples.
  assign vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      sync_q         <= 2'b11;
      hist_q         <= 3'b111;
      clk_cnt_q      <= 8'd0;
      bit_idx_q      <= 3'd0;
      data_q         <= 8'd0;
      rx_byte_q      <= 8'd0;
      rx_valid_q     <= 1'b0;
      rx_active_q    <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_overrun_q   <= 1'b0;
    end else begin
      sync_q         <= {sync_q[0], rx_serial};
      hist_q         <= {hist_q[1:0], s_rx};
      rx_frame_err_q <= 1'b0;
      rx_overrun_q   <= 1'b0;

      // Accept clears the hold. A byte landing in the STOP branch below overrides this.
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          clk_cnt_q <= 8'd0;
          bit_idx_q <= 3'd0;
          if (!s_rx) begin
            state_q     <= S_START;
            rx_active_q <= 1'b1;
          end
        end

        S_START: begin
          if (clk_cnt_q == HALF_LAST) begin
            if (vote) begin
              // Line went back high before mid-start: treat it as noise.
              state_q     <= S_IDLE;
              rx_active_q <= 1'b0;
            end else begin
              clk_cnt_q <= 8'd0;
              state_q   <= S_DATA;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 8'd1;
          end
        end

        S_DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q         <= 8'd0;
            data_q[bit_idx_q] <= vote;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 8'd1;
          end
        end

        S_STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q   <= 8'd0;
            rx_active_q <= 1'b0;
            if (vote) begin
              rx_byte_q  <= data_q;
              rx_valid_q <= 1'b1;
              // Accept in this same cycle hands off the old byte cleanly, so no overrun.
              if (rx_valid_q && !rx_ready) begin
                rx_overrun_q <= 1'b1;
              end
              state_q <= S_IDLE;
            end else begin
              rx_frame_err_q <= 1'b1;
              state_q        <= S_BREAK;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 8'd1;
          end
        end

        S_BREAK: begin
          // A held-low line (break) must not retrigger start detection.
          clk_cnt_q <= 8'd0;
          bit_idx_q <= 3'd0;
          if (s_rx) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          clk_cnt_q   <= 8'd0;
          bit_idx_q   <= 3'd0;
          rx_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_byte      = rx_byte_q;
  assign rx_valid     = rx_valid_q;
  assign rx_active    = rx_active_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_overrun   = rx_overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. A behavioural 8N1 serialiser drives the line, and expected events are queued at issue.
// Latency: a monitor compares on the falling edge whenever the DUT raises a flag or hands over a byte.
// Backpressure: rx_ready is driven low, high, or randomly per cycle, depending on the phase.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int FREQ = 1600000;
  localparam int BAUD = 10000;
  localparam int CPB  = FREQ / (16 * BAUD);   // 10 clocks per bit

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_serial = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_frame_err;
  logic       rx_overrun;

  uart_rx #(.FREQUENCY(FREQ), .BAUD_RATE(BAUD)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_serial    (rx_serial),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_active    (rx_active),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  typedef enum int { EV_BYTE = 0, EV_FERR = 1, EV_OVR = 2 } ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] dat;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  rdy_mode = 1;   // 0: ready low, 1: ready high, 2: random per cycle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.dat  = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_evt(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind=%0d byte=0x%02h, wanted nothing at %0t", k, d, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      if (e.kind == EV_BYTE) chk("rx_byte", 32'(d), 32'(e.dat));
    end
  endtask

  // Monitor: the scoreboard side, decoupled from stimulus.
  initial begin
    logic prev_v;
    logic prev_r;
    prev_v = 1'b0;
    prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rx_frame_err) expect_evt(EV_FERR, 8'h00);
        if (rx_overrun)   expect_evt(EV_OVR, 8'h00);
        if (prev_v && prev_r) chk("valid_drops_after_accept", 32'(rx_valid), 32'd0);
        if (rx_valid && rx_ready) expect_evt(EV_BYTE, rx_byte);
        prev_v = rx_valid;
        prev_r = rx_ready;
      end else begin
        prev_v = 1'b0;
        prev_r = 1'b0;
      end
    end
  end

  // Sole driver of rx_ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        default: rx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Watchdog bounds the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, wanted completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Line driver: each call holds one value for one clock, changing 1ns after posedge.
  task automatic tick(input logic v);
    rx_serial = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  // Behavioural 8N1 transmitter: start 0, eight data bits LSB first, then stop.
  // With glitchy set, some data bits get one inverted clock somewhere mid-bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic glitchy);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      int gpos;
      gpos = -1;
      if (glitchy && b >= 1 && b <= 8 && $urandom_range(0, 2) == 0) gpos = int'($urandom_range(1, 8));
      for (int c = 0; c < CPB; c++) tick((c == gpos) ? ~fr[b] : fr[b]);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1'b1);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic saw;
    logic [7:0] fixed [4];
    logic [7:0] d;
    fixed[0] = 8'h00; fixed[1] = 8'hFF; fixed[2] = 8'h55; fixed[3] = 8'hAA;

    // Reset state
    rdy_mode = 1;
    reset = 1'b1;
    rx_serial = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_byte",   32'(rx_byte), 32'd0);
    chk("reset_rx_valid",  32'(rx_valid), 32'd0);
    chk("reset_rx_active", 32'(rx_active), 32'd0);
    chk("reset_frame_err", 32'(rx_frame_err), 32'd0);
    chk("reset_overrun",   32'(rx_overrun), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(20);

    // 1: ideal frame
    push(EV_BYTE, 8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    drain("t1_a5_received");

    // 2: 3-clock low pulse is rejected, then a normal frame
    saw = 1'b0;
    tick(1'b0); tick(1'b0); tick(1'b0);
    for (int i = 0; i < 20; i++) begin
      if (rx_active) saw = 1'b1;
      tick(1'b1);
    end
    chk("t2_active_rose", 32'(saw), 32'd1);
    chk("t2_active_fell", 32'(rx_active), 32'd0);
    chk("t2_no_valid",    32'(rx_valid), 32'd0);
    push(EV_BYTE, 8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    drain("t2_3c_received");

    // 3: framing error, then a held-low break, then recovery
    push(EV_FERR, 8'h00);
    send_frame(8'h81, 1'b0, 1'b0);
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rx_active) saw = 1'b1;
      tick(1'b0);
    end
    chk("t3_no_start_in_break", 32'(saw), 32'd0);
    chk("t3_no_valid",          32'(rx_valid), 32'd0);
    idle(20);
    push(EV_BYTE, 8'h42);
    send_frame(8'h42, 1'b1, 1'b0);
    drain("t3_42_received");

    // 4: overrun with the consumer stalled; the newest byte wins
    rdy_mode = 0;
    idle(3);
    push(EV_OVR, 8'h00);
    push(EV_BYTE, 8'h22);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(30);
    chk("t4_valid_held", 32'(rx_valid), 32'd1);
    chk("t4_byte_newest", 32'(rx_byte), 32'h22);
    chk("t4_only_byte_pending", 32'(exp_q.size()), 32'd1);
    rdy_mode = 1;
    drain("t4_22_accepted");

    // 5: reset in the middle of DATA discards the partial byte
    for (int i = 0; i < 5 * CPB; i++) tick(1'b0);   // start plus four zero bits of 0xF0
    chk("t5_active_before_reset", 32'(rx_active), 32'd1);
    reset = 1'b1;
    tick(1'b1);
    tick(1'b1);
    chk("t5_rx_byte_zero",   32'(rx_byte), 32'd0);
    chk("t5_rx_valid_zero",  32'(rx_valid), 32'd0);
    chk("t5_rx_active_zero", 32'(rx_active), 32'd0);
    chk("t5_frame_err_zero", 32'(rx_frame_err), 32'd0);
    chk("t5_overrun_zero",   32'(rx_overrun), 32'd0);
    reset = 1'b0;
    idle(20);
    push(EV_BYTE, 8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0);
    drain("t5_0f_received");

    // 6: loopback-style stream with random gaps, glitches and a random-ready consumer
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      d = (n < 4) ? fixed[n] : 8'($urandom);
      push(EV_BYTE, d);
      send_frame(d, 1'b1, 1'b1);
      idle(int'($urandom_range(0, 15)));
    end
    drain("t6_stream_received");
    rdy_mode = 1;
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
